// File: rtl/ram_cmd_bridge.sv
// ram_cmd_bridge: byte-stream command front end for a 256x8 single-clock RAM.
// Decodes 'W' addr data (write), 'R' addr (single read) and 'B' addr len
// (burst read, len 0 = 256) from the RX stream. Drives the RAM ports and
// returns read data (or ERR_BYTE for an unknown opcode) on the TX stream.
// Absorbs the RAM's one-cycle registered read latency.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready     command byte stream in
//   tx_valid/tx_data/tx_ready     response byte stream out
//   ram_do_read/ram_read_addr     RAM read strobe and address
//   ram_read_data                 RAM read data, valid the cycle after the strobe
//   ram_do_write/ram_write_addr/ram_write_data  RAM write strobe, address, data
//   busy                          high whenever the FSM is not idle
//
// Optional feature: define RAM_CMD_BRIDGE_WRITE_ACK_EN to return 8'h06 on TX
// after each completed write.
module ram_cmd_bridge #(
  parameter logic [7:0] OP_WRITE = 8'h57,
  parameter logic [7:0] OP_READ  = 8'h52,
  parameter logic [7:0] OP_BURST = 8'h42,
  parameter logic [7:0] ERR_BYTE = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       ram_do_read,
  output logic [7:0] ram_read_addr,
  input  logic [7:0] ram_read_data,
  output logic       ram_do_write,
  output logic [7:0] ram_write_addr,
  output logic [7:0] ram_write_data,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 9;
`ifdef RAM_CMD_BRIDGE_WRITE_ACK_EN
  localparam logic [DW-1:0] ACK_BYTE = 8'h06;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_ARG, S_WRITE,
    S_RD_ISSUE, S_RD_CAPT, S_TX, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  op_q, op_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rx_ready_d, tx_valid_d, busy_d;
  logic [DW-1:0]  tx_data_d;
  logic           do_read_d, do_write_d;
  logic [DW-1:0]  read_addr_d, write_addr_d, write_data_d;
  logic           rx_fire;
  logic [DW-1:0]  addr_inc;

  assign rx_fire  = rx_valid && rx_ready;
  assign addr_inc = addr_q + DW'(1);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      rx_ready       <= 1'b1;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      ram_do_read    <= 1'b0;
      ram_read_addr  <= '0;
      ram_do_write   <= 1'b0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      rx_ready       <= rx_ready_d;
      tx_valid       <= tx_valid_d;
      tx_data        <= tx_data_d;
      ram_do_read    <= do_read_d;
      ram_read_addr  <= read_addr_d;
      ram_do_write   <= do_write_d;
      ram_write_addr <= write_addr_d;
      ram_write_data <= write_data_d;
      busy           <= busy_d;
    end
  end

  // Next state and next values of the registered outputs. Strobes are set on
  // the transition into the state that owns them, so they appear in that state.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid;
    tx_data_d    = tx_data;
    do_read_d    = 1'b0;
    read_addr_d  = ram_read_addr;
    do_write_d   = 1'b0;
    write_addr_d = ram_write_addr;
    write_data_d = ram_write_data;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          op_d = rx_data;
          if (rx_data == OP_WRITE || rx_data == OP_READ || rx_data == OP_BURST) begin
            state_d = S_GET_ADDR;
          end else begin
            state_d    = S_ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_fire) begin
          addr_d = rx_data;
          if (op_q == OP_READ) begin
            state_d     = S_RD_ISSUE;
            do_read_d   = 1'b1;
            read_addr_d = rx_data;
          end else begin
            state_d = S_GET_ARG;
          end
        end
      end
      S_GET_ARG: begin
        if (rx_fire) begin
          if (op_q == OP_WRITE) begin
            state_d      = S_WRITE;
            do_write_d   = 1'b1;
            write_addr_d = addr_q;
            write_data_d = rx_data;
          end else begin
            // Burst length byte of zero encodes 256
            cnt_d       = (rx_data == '0) ? CW'(256) : CW'(rx_data);
            state_d     = S_RD_ISSUE;
            do_read_d   = 1'b1;
            read_addr_d = addr_q;
          end
        end
      end
      S_WRITE: begin
`ifdef RAM_CMD_BRIDGE_WRITE_ACK_EN
        state_d    = S_TX;
        tx_valid_d = 1'b1;
        tx_data_d  = ACK_BYTE;
`else
        state_d = S_IDLE;
`endif
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        state_d    = S_TX;
        tx_valid_d = 1'b1;
        tx_data_d  = ram_read_data;
      end
      S_TX: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (op_q == OP_BURST && cnt_q > CW'(1)) begin
            cnt_d       = cnt_q - CW'(1);
            addr_d      = addr_inc;
            state_d     = S_RD_ISSUE;
            do_read_d   = 1'b1;
            read_addr_d = addr_inc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_GET_ADDR) || (state_d == S_GET_ARG);
    busy_d     = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_ram_cmd_bridge.sv
// Testbench for ram_cmd_bridge: behavioural 256x8 RAM with registered read,
// a table of single-command vectors, and hand sequences for burst wrap,
// TX backpressure and reset mid-burst.
module tb_ram_cmd_bridge;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ram_do_read;
  logic [7:0] ram_read_addr;
  logic [7:0] ram_read_data;
  logic       ram_do_write;
  logic [7:0] ram_write_addr;
  logic [7:0] ram_write_data;
  logic       busy;

  ram_cmd_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .ram_do_read    (ram_do_read),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .ram_do_write   (ram_do_write),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .busy           (busy)
  );

`ifdef RAM_CMD_BRIDGE_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; pre_* is a bench-only preload port
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_do_write) mem[ram_write_addr] <= ram_write_data;
    if (ram_do_read) ram_read_data <= mem[ram_read_addr];
  end

  // Monitors, sampled mid-cycle
  logic [7:0] txq [$];
  logic [7:0] rdq [$];
  int         wr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] wr_addr_l = '0, wr_data_l = '0;
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
    if (ram_do_read) rdq.push_back(ram_read_addr);
    if (ram_do_write) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_l <= ram_write_addr;
      wr_data_l <= ram_write_data;
    end
    if (ram_do_read && ram_do_write) both_cnt <= both_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] a);
    return 8'(32'(a) * 3 + 1);
  endfunction

  // Called and returns at posedge+1; holds the byte until it transfers
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rx_accept", 32'(rx_ready), 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
    bit         exp_tx;
    logic [7:0] exp_data;
    int         exp_lat;   // cycles from the last RX transfer cycle to tx_valid
    bit         exp_wr;
    logic [7:0] exp_waddr, exp_wdata;
  } vec_t;
  vec_t vq [$];

  task automatic add_vec(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input bit etx, input logic [7:0] ed,
                         input int elat, input bit ewr, input logic [7:0] wa,
                         input logic [7:0] wd);
    vec_t v;
    v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.exp_tx = etx; v.exp_data = ed; v.exp_lat = elat;
    v.exp_wr = ewr; v.exp_waddr = wa; v.exp_wdata = wd;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, wr0, rd0, lat, k;
    logic [7:0] bl [3];

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_do_read", 32'(ram_do_read), 0);
    chk("rst_do_write", 32'(ram_do_write), 0);
    chk("rst_read_addr", 32'(ram_read_addr), 0);
    chk("rst_write_addr", 32'(ram_write_addr), 0);
    chk("rst_write_data", 32'(ram_write_data), 0);
    chk("rst_busy", 32'(busy), 0);

    for (int a = 0; a < 256; a++) poke(8'(a), pat(8'(a)));
    rst = 1'b0;
    @(posedge clk); #1;

    // nb, bytes, exp_tx, exp_data, exp_lat, exp_wr, waddr, wdata
    add_vec(3, 8'h57, 8'h10, 8'hA5, ACK,  8'h06, 2, 1'b1, 8'h10, 8'hA5);
    add_vec(2, 8'h52, 8'h10, 8'h00, 1'b1, 8'hA5, 3, 1'b0, 8'h00, 8'h00);
    add_vec(1, 8'h7E, 8'h00, 8'h00, 1'b1, 8'h3F, 1, 1'b0, 8'h00, 8'h00);
    add_vec(2, 8'h52, 8'h00, 8'h00, 1'b1, 8'h01, 3, 1'b0, 8'h00, 8'h00);
    add_vec(2, 8'h52, 8'hFF, 8'h00, 1'b1, 8'hFE, 3, 1'b0, 8'h00, 8'h00);
    add_vec(3, 8'h42, 8'h40, 8'h01, 1'b1, 8'hC1, 3, 1'b0, 8'h00, 8'h00);
    add_vec(1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h3F, 1, 1'b0, 8'h00, 8'h00);
    add_vec(3, 8'h57, 8'hFF, 8'h3C, ACK,  8'h06, 2, 1'b1, 8'hFF, 8'h3C);
    add_vec(2, 8'h52, 8'hFF, 8'h00, 1'b1, 8'h3C, 3, 1'b0, 8'h00, 8'h00);
    add_vec(3, 8'h57, 8'h20, 8'h5A, ACK,  8'h06, 2, 1'b1, 8'h20, 8'h5A);
    add_vec(2, 8'h52, 8'h20, 8'h00, 1'b1, 8'h5A, 3, 1'b0, 8'h00, 8'h00);

    foreach (vq[v]) begin
      tx0 = txq.size();
      wr0 = wr_cnt;
      bl[0] = vq[v].b0; bl[1] = vq[v].b1; bl[2] = vq[v].b2;
      for (int j = 0; j < vq[v].nb; j++) send_byte(bl[j]);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
        if (lat == 0 && tx_valid) lat = i + 1;
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_tx_cnt", v), 32'(txq.size() - tx0), vq[v].exp_tx ? 1 : 0);
      if (vq[v].exp_tx) begin
        chk($sformatf("v%0d_tx_data", v), 32'(txq[tx0]), 32'(vq[v].exp_data));
        chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vq[v].exp_lat));
      end
      chk($sformatf("v%0d_wr_cnt", v), 32'(wr_cnt - wr0), vq[v].exp_wr ? 1 : 0);
      if (vq[v].exp_wr) begin
        chk($sformatf("v%0d_wr_addr", v), 32'(wr_addr_l), 32'(vq[v].exp_waddr));
        chk($sformatf("v%0d_wr_data", v), 32'(wr_data_l), 32'(vq[v].exp_wdata));
      end
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 0);
      chk($sformatf("v%0d_rx_ready_end", v), 32'(rx_ready), 1);
    end
    chk("mem20", 32'(mem[8'h20]), 'h5A);

    // Burst crossing the top of the address space
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    tx0 = txq.size(); rd0 = rdq.size();
    send_byte(8'h42); send_byte(8'hFE); send_byte(8'h03);
    k = 0;
    while (!((txq.size() - tx0) == 3 && !busy) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("wrap_tx_cnt", 32'(txq.size() - tx0), 3);
    chk("wrap_b0", 32'(txq[tx0]), 'h11);
    chk("wrap_b1", 32'(txq[tx0 + 1]), 'h22);
    chk("wrap_b2", 32'(txq[tx0 + 2]), 'h33);
    chk("wrap_rd_cnt", 32'(rdq.size() - rd0), 3);
    chk("wrap_ra0", 32'(rdq[rd0]), 'hFE);
    chk("wrap_ra1", 32'(rdq[rd0 + 1]), 'hFF);
    chk("wrap_ra2", 32'(rdq[rd0 + 2]), 'h00);
    chk("wrap_busy", 32'(busy), 0);

    // TX backpressure on a single read of 0x10 (holds A5)
    tx_ready = 1'b0;
    tx0 = txq.size(); rd0 = rdq.size();
    send_byte(8'h52); send_byte(8'h10);
    k = 0;
    while (!tx_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("bp_valid_seen", 32'(tx_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(tx_valid), 1);
      chk($sformatf("bp%0d_data", i), 32'(tx_data), 'hA5);
      chk($sformatf("bp%0d_rx_ready", i), 32'(rx_ready), 0);
      @(posedge clk); #1;
    end
    chk("bp_rd_pulses", 32'(rdq.size() - rd0), 1);
    chk("bp_no_early_tx", 32'(txq.size() - tx0), 0);
    tx_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_tx_cnt", 32'(txq.size() - tx0), 1);
    chk("bp_tx_data", 32'(txq[tx0]), 'hA5);
    chk("bp_busy", 32'(busy), 0);

    // Reset in the middle of a 256-byte burst from 0x00
    tx0 = txq.size(); wr0 = wr_cnt;
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h00);
    k = 0;
    while ((txq.size() - tx0) < 3 && k < 60) begin
      @(posedge clk); #1; k++;
    end
    chk("mid_tx_cnt", 32'(txq.size() - tx0), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 1);
    chk("mid_rst_do_read", 32'(ram_do_read), 0);
    chk("mid_rst_read_addr", 32'(ram_read_addr), 0);
    rst = 1'b0;
    chk("mid_b0", 32'(txq[tx0]), 'h33);
    chk("mid_b1", 32'(txq[tx0 + 1]), 'h04);
    chk("mid_b2", 32'(txq[tx0 + 2]), 'h07);
    repeat (8) begin @(posedge clk); #1; end
    chk("mid_no_more_tx", 32'(txq.size() - tx0), 3);
    chk("mid_no_write", 32'(wr_cnt - wr0), 0);
    tx0 = txq.size();
    send_byte(8'h52); send_byte(8'h05);
    k = 0;
    while ((txq.size() - tx0) < 1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("post_rst_tx_cnt", 32'(txq.size() - tx0), 1);
    chk("post_rst_data", 32'(txq[tx0]), 'h10);

    chk("never_both_strobes", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
